// File: rtl/ecc_err_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : ecc_err_pkg                                                  |
// | Purpose  : Shared constants for the AXI ECC error monitor               |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
package ecc_err_pkg;

  // Bit positions inside the decoder error flag vector
  localparam int ERR_SINGLE = 0;
  localparam int ERR_DOUBLE = 1;

  // AXI response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // True for responses that report success and may be overridden by an error
  function automatic logic resp_is_ok(input logic [1:0] resp);
    return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : fifo_v3                                                      |
// | Purpose  : Synchronous FIFO, common_cells compatible port list          |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] C_LAST_PTR = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0]   C_DEPTH    = (ADDR_DEPTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_DEPTH-1:0] r_wr_ptr;
  logic [ADDR_DEPTH-1:0] r_rd_ptr;
  logic [ADDR_DEPTH:0]   r_cnt;
  logic                  w_write;
  logic                  w_read;
  logic                  w_bypass;
  logic                  unused_testmode;

  // Test mode has no effect in this implementation (no clock gating inside)
  assign unused_testmode = testmode_i;

  assign full_o   = (r_cnt == C_DEPTH);
  assign empty_o  = (r_cnt == '0) && !(FALL_THROUGH && push_i);
  assign usage_o  = r_cnt[ADDR_DEPTH-1:0];
  assign w_write  = push_i && !full_o;
  assign w_read   = pop_i && !empty_o;
  assign w_bypass = FALL_THROUGH && (r_cnt == '0) && w_write && w_read;

  // Head of queue, or the incoming word when falling through an empty FIFO
  always_comb begin
    data_o = r_mem[r_rd_ptr];
    if (FALL_THROUGH && (r_cnt == '0)) begin
      data_o = data_i;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (w_write && !w_bypass) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (!w_bypass) begin
      if (w_write) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_read) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_write && !w_read) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_read && !w_write) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_ecc_err_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : axi_ecc_err_monitor                                          |
// | Purpose  : Counts SECDED errors on the W stream, captures the first     |
// |            error and forces SLVERR on bursts with uncorrectable beats   |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module axi_ecc_err_monitor
  import ecc_err_pkg::*;
#(
  parameter int unsigned NB_ECC_BITS     = 7,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [1:0]             err_i,
  input  logic [NB_ECC_BITS-1:0] syndrome_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic                   w_last_i,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [1:0]             b_resp_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [1:0]             b_resp_o,
  output logic [CNT_WIDTH-1:0]   corr_cnt_o,
  output logic [CNT_WIDTH-1:0]   uncorr_cnt_o,
  output logic                   first_err_valid_o,
  output logic [1:0]             first_err_type_o,
  output logic [NB_ECC_BITS-1:0] first_syndrome_o
);

  localparam int unsigned C_ADDR_DEPTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_head_flag;
  logic                    w_stall;
  logic                    w_beat;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_err_any;
  logic [C_ADDR_DEPTH-1:0] unused_usage;
  logic                    r_sticky;
  logic [CNT_WIDTH-1:0]    r_corr_cnt;
  logic [CNT_WIDTH-1:0]    r_uncorr_cnt;
  logic                    r_first_valid;
  logic [1:0]              r_first_type;
  logic [NB_ECC_BITS-1:0]  r_first_syndrome;

  // Only a last beat needs a free flag slot, so only last beats are held off
  assign w_stall   = w_full && w_last_i;
  assign w_valid_o = w_valid_i && !w_stall;
  assign w_ready_o = w_ready_i && !w_stall;
  assign w_beat    = w_valid_i && w_ready_o;
  assign w_push    = w_beat && w_last_i;
  assign w_err_any = |err_i;

  // A B response cannot be matched to a burst until its flag is queued
  assign b_valid_o = b_valid_i && !w_empty;
  assign b_ready_o = b_ready_i && !w_empty;
  assign w_pop     = b_valid_o && b_ready_i;
  assign b_resp_o  = (w_head_flag && resp_is_ok(b_resp_i)) ? RESP_SLVERR : b_resp_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (1),
    .DEPTH        (MAX_OUTSTANDING)
  ) u_flag_fifo (
    .clk_i      (clk_i),
    .rst_ni     (!rst_i),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .usage_o    (unused_usage),
    .data_i     (r_sticky || err_i[ERR_DOUBLE]),
    .push_i     (w_push),
    .data_o     (w_head_flag),
    .pop_i      (w_pop)
  );

  // Accumulate uncorrectable beats of the burst in progress
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sticky <= 1'b0;
    end else if (w_beat) begin
      r_sticky <= w_last_i ? 1'b0 : (r_sticky || err_i[ERR_DOUBLE]);
    end
  end

  // Saturating error counters; a beat coinciding with clear counts as the first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (clear_i) begin
      r_corr_cnt   <= (w_beat && err_i[ERR_SINGLE]) ? CNT_WIDTH'(1) : '0;
      r_uncorr_cnt <= (w_beat && err_i[ERR_DOUBLE]) ? CNT_WIDTH'(1) : '0;
    end else begin
      if (w_beat && err_i[ERR_SINGLE] && (r_corr_cnt != '1)) begin
        r_corr_cnt <= r_corr_cnt + 1'b1;
      end
      if (w_beat && err_i[ERR_DOUBLE] && (r_uncorr_cnt != '1)) begin
        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
      end
    end
  end

  // Capture type and syndrome of the first erroneous beat since reset/clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_first_valid    <= 1'b0;
      r_first_type     <= '0;
      r_first_syndrome <= '0;
    end else if (clear_i) begin
      r_first_valid    <= w_beat && w_err_any;
      r_first_type     <= (w_beat && w_err_any) ? err_i : '0;
      r_first_syndrome <= (w_beat && w_err_any) ? syndrome_i : '0;
    end else if (w_beat && w_err_any && !r_first_valid) begin
      r_first_valid    <= 1'b1;
      r_first_type     <= err_i;
      r_first_syndrome <= syndrome_i;
    end
  end

  assign corr_cnt_o        = r_corr_cnt;
  assign uncorr_cnt_o      = r_uncorr_cnt;
  assign first_err_valid_o = r_first_valid;
  assign first_err_type_o  = r_first_type;
  assign first_syndrome_o  = r_first_syndrome;

endmodule
`default_nettype wire

// File: doc/axi_ecc_err_monitor.md
# axi_ecc_err_monitor

Monitors the write stream leaving the AXI SECDED decoder stage and acts on its per-beat error flags before the write reaches memory. Counts correctable and uncorrectable beats and captures the first error's syndrome. Forces SLVERR on the B response of every write burst that contained an uncorrectable beat. Sits directly downstream of the ECC decoder on the W/B channels; all other channels bypass it.

## Interface
- NB_ECC_BITS, 7: syndrome width (7 for 32-bit data, 8 for 64-bit data).
- MAX_OUTSTANDING, 4: maximum number of write bursts completed on W but not yet responded on B; must be ≥1.
- CNT_WIDTH, 16: width of each saturating error counter.

- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear of counters and capture registers.
- err_i  in  2  decoder error flags for the current W beat; [0] = single (corrected), [1] = double (uncorrectable).
- syndrome_i  in  NB_ECC_BITS  decoder syndrome for the current W beat.
- w_valid_i / w_ready_o / w_last_i  in/out/in  1 each  upstream W handshake.
- w_valid_o / w_ready_i  out/in  1 each  downstream W handshake; W payload is not routed through this block.
- b_valid_i / b_ready_o / b_resp_i  in/out/in  1/1/2  B channel from the slave.
- b_valid_o / b_ready_i / b_resp_o  out/in/out  1/1/2  B channel to the master.
- corr_cnt_o  out  CNT_WIDTH  count of accepted beats with err_i[0].
- uncorr_cnt_o  out  CNT_WIDTH  count of accepted beats with err_i[1].
- first_err_valid_o  out  1  set when a first error has been captured.
- first_err_type_o  out  2  err_i value of the first erroneous beat.
- first_syndrome_o  out  NB_ECC_BITS  syndrome of the first erroneous beat.

## Operation
- Beat accepted = w_valid_i & w_ready_o. Only accepted beats are evaluated.
- Flag FIFO: 1 bit per burst, depth MAX_OUTSTANDING. Burst flag = sticky OR of err_i[1] over all beats of the burst, including the last beat.
  - Sticky register is cleared on the accepted last beat.
  - The FIFO is pushed with (sticky | err_i[1]) on the accepted last beat.
- W gating:
  - w_valid_o = w_valid_i & ~(full & w_last_i).
  - w_ready_o = w_ready_i & ~(full & w_last_i).
  - Non-last beats are never stalled. Last beats stall while the FIFO is full, even if a pop occurs in the same cycle; there is no combinational pop-through path.
- B path:
  - b_valid_o = b_valid_i & ~empty.
  - b_ready_o = b_ready_i & ~empty.
  - The FIFO is popped on b_valid_o & b_ready_i.
  - b_resp_o = SLVERR (2'b10) if the head flag is set and b_resp_i is OKAY or EXOKAY; otherwise b_resp_i is passed through unchanged (existing SLVERR/DECERR preserved).
  - AXI ordering guarantees B never precedes its last W beat. While the FIFO is empty, B is held off.
  - Responses are in order: all IDs share one FIFO.
- Counters: increment by 1 on each accepted beat with the corresponding err bit, and saturate at all-ones. A beat with both bits set increments both counters.
- Capture: on the first accepted beat with err_i ≠ 0 while first_err_valid_o = 0, latch err_i and syndrome_i and set valid. Held until clear_i.
- clear_i: zeroes counters and the capture registers. An error beat accepted in the same cycle is applied after the clear: counter reads 1, and the capture latches that beat. clear_i does not touch the FIFO or the sticky flag.
- Reset: FIFO empty, sticky = 0, counters = 0, first_err_valid_o = 0, type/syndrome = 0. b_valid_o = 0 and b_ready_o = 0 while the FIFO is empty. w_ready_o follows w_ready_i.

## Timing
- W and B handshake paths are combinational; no added latency.
- Counters and capture outputs update on the clock edge following the accepted beat (1-cycle latency).
- A FIFO push is visible to B in the cycle after the push edge. A B response in the same cycle as its own last W beat is therefore impossible and must not occur.
- Asynchronous reset mid-burst discards the sticky flag and all pending FIFO entries.

## Structure
- Shared package ecc_err_pkg:
  - err bit indices ERR_SINGLE = 0, ERR_DOUBLE = 1.
  - AXI resp constants RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR.
- Flag FIFO: common_cells fifo_v3 instance with DATA_WIDTH = 1, DEPTH = MAX_OUTSTANDING, FALL_THROUGH = 0, flush tied low.
- Everything else is local registers.

## Test plan
- 4-beat burst, err_i = 2'b01 on beat 2 → corr_cnt_o = 1 one cycle later; first_err_type_o = 01 with that beat's syndrome; B OKAY passes as OKAY.
- 2-beat burst, err_i = 2'b10 on last beat only → uncorr_cnt_o = 1; following B OKAY returns as SLVERR. Next clean burst's B returns OKAY.
- MAX_OUTSTANDING = 2, three clean bursts with b_ready_i held low → third last beat stalls (w_ready_o = 0, w_valid_o = 0) until one B handshake completes, then proceeds the next cycle.
- CNT_WIDTH = 4, 17 correctable beats → corr_cnt_o saturates at 15.
- clear_i asserted in the same cycle as an accepted err_i = 2'b10 beat → uncorr_cnt_o = 1, capture = that beat; pending SLVERR flags are unaffected.
- rst_i pulsed with 2 bursts outstanding → FIFO empty; slave B then held off (b_ready_o = 0); all outputs at reset values.
